// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-ALU pipeline register with a 2-entry skid buffer (M drives out_*, S absorbs overflow).
// Optional writeback-to-operand forwarding on held entries when ID_EX_FWD_EN is defined.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_op1,
    input  logic [DATA_W-1:0] in_op2,
    input  logic [CTRL_W-1:0] in_alu_ctrl,
    input  logic              in_sub,
    input  logic              in_sign,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic              in_we,
    input  logic [DATA_W-1:0] in_pc,
`ifdef ID_EX_FWD_EN
    input  logic [ADDR_W-1:0] in_rs1,
    input  logic [ADDR_W-1:0] in_rs2,
    input  logic              in_use_rs1,
    input  logic              in_use_rs2,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_op1,
    output logic [DATA_W-1:0] out_op2,
    output logic [CTRL_W-1:0] out_alu_ctrl,
    output logic              out_sub,
    output logic              out_sign,
    output logic [ADDR_W-1:0] out_rd,
    output logic              out_we,
    output logic [DATA_W-1:0] out_pc
);

    typedef struct packed {
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
        logic [CTRL_W-1:0] alu_ctrl;
        logic              sub;
        logic              sign;
        logic [ADDR_W-1:0] rd;
        logic              we;
        logic [DATA_W-1:0] pc;
`ifdef ID_EX_FWD_EN
        logic [ADDR_W-1:0] rs1;
        logic [ADDR_W-1:0] rs2;
        logic              use_rs1;
        logic              use_rs2;
`endif
    } entry_t;

    entry_t m_q;
    entry_t s_q;
    logic   m_v;
    logic   s_v;

    entry_t in_e;
    entry_t m_fwd;
    entry_t s_fwd;
    logic   acc;
    logic   iss;

`ifdef ID_EX_FWD_EN
    function automatic entry_t apply_fwd(input entry_t e, input logic we,
                                         input logic [ADDR_W-1:0] rd,
                                         input logic [DATA_W-1:0] data);
        entry_t r;
        r = e;
        if (we && (rd != '0)) begin
            if (e.use_rs1 && (e.rs1 == rd)) r.op1 = data;
            if (e.use_rs2 && (e.rs2 == rd)) r.op2 = data;
        end
        return r;
    endfunction
`endif

    always_comb begin
        in_e          = '0;
        in_e.op1      = in_op1;
        in_e.op2      = in_op2;
        in_e.alu_ctrl = in_alu_ctrl;
        in_e.sub      = in_sub;
        in_e.sign     = in_sign;
        in_e.rd       = in_rd;
        in_e.we       = in_we;
        in_e.pc       = in_pc;
        m_fwd         = m_q;
        s_fwd         = s_q;
`ifdef ID_EX_FWD_EN
        in_e.rs1      = in_rs1;
        in_e.rs2      = in_rs2;
        in_e.use_rs1  = in_use_rs1;
        in_e.use_rs2  = in_use_rs2;
        // Every path into M or S sees the current writeback value.
        in_e          = apply_fwd(in_e, wb_we, wb_rd, wb_data);
        m_fwd         = apply_fwd(m_q, wb_we, wb_rd, wb_data);
        s_fwd         = apply_fwd(s_q, wb_we, wb_rd, wb_data);
`endif
    end

    // in_ready depends only on the S valid flop, so out_ready never reaches decode.
    assign in_ready = ~s_v;
    assign acc      = in_valid & in_ready;
    assign iss      = m_v & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            m_v <= 1'b0;
            s_v <= 1'b0;
            m_q <= '0;
            s_q <= '0;
        end else if (flush) begin
            m_v <= 1'b0;
            s_v <= 1'b0;
        end else if (!m_v || iss) begin
            if (s_v) begin
                m_q <= s_fwd;
                m_v <= 1'b1;
                s_v <= 1'b0;
            end else begin
                m_v <= acc;
                if (acc) m_q <= in_e;
            end
        end else begin
            m_q <= m_fwd;
            if (acc) begin
                s_q <= in_e;
                s_v <= 1'b1;
            end else begin
                s_q <= s_fwd;
            end
        end
    end

    assign out_valid    = m_v;
    assign out_op1      = m_q.op1;
    assign out_op2      = m_q.op2;
    assign out_alu_ctrl = m_q.alu_ctrl;
    assign out_sub      = m_q.sub;
    assign out_sign     = m_q.sign;
    assign out_rd       = m_q.rd;
    assign out_we       = m_q.we;
    assign out_pc       = m_q.pc;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: randomized and directed checks of id_ex_stage against a 2-deep queue model.
// Forwarding scenarios are exercised when ID_EX_FWD_EN is defined.
module tb_id_ex_stage;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int CTRL_W = 4;
`ifdef ID_EX_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [3:0]  ctrl;
        logic        sub;
        logic        sign;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        u1;
        logic        u2;
    } txn_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_op1;
    logic [DATA_W-1:0] in_op2;
    logic [CTRL_W-1:0] in_alu_ctrl;
    logic              in_sub;
    logic              in_sign;
    logic [ADDR_W-1:0] in_rd;
    logic              in_we;
    logic [DATA_W-1:0] in_pc;
    logic [ADDR_W-1:0] in_rs1;
    logic [ADDR_W-1:0] in_rs2;
    logic              in_use_rs1;
    logic              in_use_rs2;
    logic              wb_we;
    logic [ADDR_W-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_op1;
    logic [DATA_W-1:0] out_op2;
    logic [CTRL_W-1:0] out_alu_ctrl;
    logic              out_sub;
    logic              out_sign;
    logic [ADDR_W-1:0] out_rd;
    logic              out_we;
    logic [DATA_W-1:0] out_pc;

    txn_t        q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] seq = 32'd1;

    id_ex_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CTRL_W(CTRL_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op1      (in_op1),
        .in_op2      (in_op2),
        .in_alu_ctrl (in_alu_ctrl),
        .in_sub      (in_sub),
        .in_sign     (in_sign),
        .in_rd       (in_rd),
        .in_we       (in_we),
        .in_pc       (in_pc),
`ifdef ID_EX_FWD_EN
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_use_rs1  (in_use_rs1),
        .in_use_rs2  (in_use_rs2),
        .wb_we       (wb_we),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
`endif
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_op1     (out_op1),
        .out_op2     (out_op2),
        .out_alu_ctrl(out_alu_ctrl),
        .out_sub     (out_sub),
        .out_sign    (out_sign),
        .out_rd      (out_rd),
        .out_we      (out_we),
        .out_pc      (out_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // A writeback to a register an entry reads overrides that operand.
    function automatic txn_t apply_wb(input txn_t t);
        txn_t r;
        r = t;
        if (FWD_EN && wb_we && (wb_rd != 5'd0)) begin
            if (t.u1 && (t.rs1 == wb_rd)) r.op1 = wb_data;
            if (t.u2 && (t.rs2 == wb_rd)) r.op2 = wb_data;
        end
        return r;
    endfunction

    task automatic rand_payload(input bit rand_wb);
        in_op1      = $urandom;
        in_op2      = $urandom;
        in_alu_ctrl = 4'($urandom);
        in_sub      = 1'($urandom);
        in_sign     = 1'($urandom);
        in_rd       = 5'($urandom);
        in_we       = 1'($urandom);
        in_pc       = seq;
        seq         = seq + 32'd1;
        in_rs1      = 5'($urandom_range(0, 3));
        in_rs2      = 5'($urandom_range(0, 3));
        in_use_rs1  = 1'($urandom);
        in_use_rs2  = 1'($urandom);
        wb_we       = rand_wb ? 1'($urandom) : 1'b0;
        wb_rd       = 5'($urandom_range(0, 3));
        wb_data     = $urandom;
    endtask

    task automatic compare_outputs();
        chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
        chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
        if (q.size() > 0) begin
            chk("op1", out_op1, q[0].op1);
            chk("op2", out_op2, q[0].op2);
            chk("alu_ctrl", 32'(out_alu_ctrl), 32'(q[0].ctrl));
            chk("sub", 32'(out_sub), 32'(q[0].sub));
            chk("sign", 32'(out_sign), 32'(q[0].sign));
            chk("rd", 32'(out_rd), 32'(q[0].rd));
            chk("we", 32'(out_we), 32'(q[0].we));
            chk("pc", out_pc, q[0].pc);
        end
    endtask

    // One clock: drive controls, advance the queue model at the edge, compare 1 time unit later.
    task automatic step(input logic v, input logic r, input logic fl, input logic rs);
        txn_t cur;
        bit   acc;
        bit   iss;
        in_valid  = v;
        out_ready = r;
        flush     = fl;
        rst       = rs;
        cur.op1  = in_op1;
        cur.op2  = in_op2;
        cur.ctrl = in_alu_ctrl;
        cur.sub  = in_sub;
        cur.sign = in_sign;
        cur.rd   = in_rd;
        cur.we   = in_we;
        cur.pc   = in_pc;
        cur.rs1  = in_rs1;
        cur.rs2  = in_rs2;
        cur.u1   = in_use_rs1;
        cur.u2   = in_use_rs2;
        @(posedge clk);
        acc = v && (q.size() < 2);
        iss = r && (q.size() > 0);
        if (rs || fl) begin
            q.delete();
        end else begin
            if (iss) void'(q.pop_front());
            foreach (q[i]) q[i] = apply_wb(q[i]);
            if (acc) q.push_back(apply_wb(cur));
        end
        #1;
        compare_outputs();
        if (rs) begin
            chk("rst_op1", out_op1, 32'd0);
            chk("rst_op2", out_op2, 32'd0);
            chk("rst_pc", out_pc, 32'd0);
            chk("rst_ctrl", 32'(out_alu_ctrl), 32'd0);
            chk("rst_rd", 32'(out_rd), 32'd0);
            chk("rst_flags", {29'd0, out_sub, out_sign, out_we}, 32'd0);
        end
    endtask

    initial begin
        rand_payload(1'b0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        rst       = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);

        // Full-rate stream
        for (int k = 1; k <= 4; k++) begin
            rand_payload(1'b0);
            in_op1 = 32'(k);
            step(1'b1, 1'b1, 1'b0, 1'b0);
            chk("stream_op1", out_op1, 32'(k));
            chk("stream_ready", 32'(in_ready), 32'd1);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0);

        // Backpressure into the skid entry, then drain in order
        rand_payload(1'b0); in_op1 = 32'd11;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("bp_ready1", 32'(in_ready), 32'd1);
        rand_payload(1'b0); in_op1 = 32'd12;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("bp_ready2", 32'(in_ready), 32'd0);
        chk("bp_hold", out_op1, 32'd11);
        rand_payload(1'b0); in_op1 = 32'd13;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("bp_hold2", out_op1, 32'd11);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("bp_second", out_op1, 32'd12);
        chk("bp_ready_back", 32'(in_ready), 32'd1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("bp_empty", 32'(out_valid), 32'd0);

        // Flush with both entries full and a new input offered
        rand_payload(1'b0); in_op1 = 32'd21;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        rand_payload(1'b0); in_op1 = 32'd22;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        rand_payload(1'b0); in_op1 = 32'd23;
        step(1'b1, 1'b0, 1'b1, 1'b0);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_ready", 32'(in_ready), 32'd1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("flush_no_c", 32'(out_valid), 32'd0);

        // Reset with both entries full
        rand_payload(1'b0); in_op1 = 32'd31;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        rand_payload(1'b0); in_op1 = 32'd32;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk("rstmid_valid", 32'(out_valid), 32'd0);
        chk("rstmid_ready", 32'(in_ready), 32'd1);

`ifdef ID_EX_FWD_EN
        rand_payload(1'b0);
        in_op1 = 32'h10; in_rs1 = 5'd5; in_use_rs1 = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("fwd_base", out_op1, 32'h10);
        wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEAD;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("fwd_hit", out_op1, 32'hDEAD);
        wb_rd = 5'd0; wb_data = 32'hBEEF;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("fwd_x0", out_op1, 32'hDEAD);
        wb_we = 1'b0;
        step(1'b0, 1'b1, 1'b0, 1'b0);
`endif

        // Alternating backpressure with continuous input
        for (int i = 0; i < 1000; i++) begin
            rand_payload(1'b1);
            step(1'b1, (i % 2) == 0, 1'b0, 1'b0);
        end

        // Fully random traffic with occasional flush and reset
        for (int i = 0; i < 1500; i++) begin
            rand_payload(1'b1);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 31) == 0, $urandom_range(0, 199) == 0);
        end

        rand_payload(1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("final_empty", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
